dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/arb_wait_counter.sv | 36 +++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter and arb_wait_counter).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOST_RSP = 2'd1,
    HOST_ACK = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;
  localparam int unsigned STAT_W           = 32;

  // Bits needed to hold 0..limit, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags cnt == LIMIT.
module arb_wait_counter #(
  parameter int unsigned   W     = 1,
  parameter logic [W-1:0]  LIMIT = '1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MEM stage (priority) and a host port.
// Optional DMEM_ARB_STATS_EN adds saturating host-grant and cpu-stall counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int unsigned WAIT_W  = cnt_width(MAX_WAIT)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_host_grants,
  output logic [STAT_W-1:0] stat_cpu_stalls
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  // Host handshake: host_req and its fields stay stable from assertion until the
  // one-cycle host_ack pulse; the host drops host_req the cycle after the ack.
  arb_state_e        state_q, state_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_wr_q, host_wr_d;

  logic              cpu_req;
  logic              host_grant;
  logic              wait_inc;
  logic              wait_at_limit;
  logic [WAIT_W-1:0] wait_cnt;

  assign cpu_req    = cpu_ren | cpu_wen;
  assign host_grant = (state_q == IDLE) && host_req && (!cpu_req || wait_at_limit);
  assign wait_inc   = (state_q == IDLE) && host_req && cpu_req && !host_grant;

  arb_wait_counter #(
    .W     (WAIT_W),
    .LIMIT (WAIT_LIM)
  ) u_wait_cnt (
    .clk      (clk),
    .arst     (arst),
    .clr      (host_grant),
    .inc      (wait_inc),
    .cnt      (wait_cnt),
    .at_limit (wait_at_limit)
  );

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_ren   = cpu_ren;
    mem_wen   = cpu_wen;
    cpu_stall = 1'b0;
    if (host_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_ren   = !host_wen;
      mem_wen   = host_wen;
      cpu_stall = cpu_req;
    end
  end

  // A CPU read issued in HOST_RSP returns in HOST_ACK, after the host capture.
  always_comb begin
    state_d      = state_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_wr_d    = host_wr_q;
    case (state_q)
      IDLE: begin
        if (host_grant) begin
          state_d   = HOST_RSP;
          host_wr_d = host_wen;
        end
      end
      HOST_RSP: begin
        state_d      = HOST_ACK;
        host_ack_d   = 1'b1;
        host_rdata_d = host_wr_q ? '0 : mem_rdata;
      end
      HOST_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      host_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      host_wr_q    <= host_wr_d;
    end
  end

  assign cpu_rdata    = mem_rdata;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt;

`ifdef DMEM_ARB_STATS_EN
  logic grants_full, stalls_full;

  arb_wait_counter #(
    .W     (STAT_W),
    .LIMIT ('1)
  ) u_stat_grants (
    .clk      (clk),
    .arst     (arst),
    .clr      (1'b0),
    .inc      (host_grant & ~grants_full),
    .cnt      (stat_host_grants),
    .at_limit (grants_full)
  );

  arb_wait_counter #(
    .W     (STAT_W),
    .LIMIT ('1)
  ) u_stat_stalls (
    .clk      (clk),
    .arst     (arst),
    .clr      (1'b0),
    .inc      (cpu_stall & ~stalls_full),
    .cnt      (stat_cpu_stalls),
    .at_limit (stalls_full)
  );
`endif

endmodule
